// File: rtl/prog_loader_if.sv
// Program-load bus: the inbound word stream plus the command-memory write port.
// The master modport is the word source / memory side, the slave modport is the loader.
interface prog_loader_if #(
    parameter int CMD_WIDTH      = 128,
    parameter int CMD_ADDR_WIDTH = 8,
    parameter int WORD_WIDTH     = 32
);
    logic [WORD_WIDTH-1:0]     word_in;
    logic                      word_valid;
    logic                      word_ready;
    logic                      write_prog_enable;
    logic [CMD_ADDR_WIDTH-1:0] cmd_addr;
    logic [CMD_WIDTH-1:0]      cmd_data;

    modport master (
        output word_in, word_valid,
        input  word_ready, write_prog_enable, cmd_addr, cmd_data
    );

    modport slave (
        input  word_in, word_valid,
        output word_ready, write_prog_enable, cmd_addr, cmd_data
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs a stream of program words into commands (first word in
// the MSBs) and writes them to consecutive command-memory addresses while
// holding the processor in reset.
module prog_loader #(
    parameter int CMD_WIDTH      = 128,
    parameter int CMD_ADDR_WIDTH = 8,
    parameter int WORD_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CMD_ADDR_WIDTH-1:0] base_addr,
    input  logic [CMD_ADDR_WIDTH:0]   num_cmds,
    prog_loader_if.slave              bus,
    output logic                      proc_hold,
    output logic                      busy,
    output logic                      done
);
    localparam int WPC   = CMD_WIDTH / WORD_WIDTH;
    localparam int WCW   = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int CNT_W = CMD_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                    state_q;
    logic [CMD_ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]          remain_q;
    logic [WCW-1:0]            wcnt_q;
    logic [CMD_WIDTH-1:0]      pack_q;
    logic [CMD_WIDTH-1:0]      pack_d;
    logic                      we_q;
    logic [CMD_ADDR_WIDTH-1:0] cmd_addr_q;
    logic [CMD_WIDTH-1:0]      cmd_data_q;
    logic                      busy_q;
    logic                      hold_q;
    logic                      done_q;

    // Pack register after accepting the current word: older words move toward the MSBs.
    assign pack_d = (pack_q << WORD_WIDTH) | CMD_WIDTH'(bus.word_in);

    assign bus.word_ready        = (state_q == LOAD);
    assign bus.write_prog_enable = we_q;
    assign bus.cmd_addr          = cmd_addr_q;
    assign bus.cmd_data          = cmd_data_q;
    assign busy                  = busy_q;
    assign proc_hold             = hold_q;
    assign done                  = done_q;

    // Load sequencer: state, counters, packing and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            wcnt_q     <= '0;
            pack_q     <= '0;
            we_q       <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            busy_q     <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // start beats a simultaneous abort simply because abort is not looked at here
                    done_q <= 1'b0;
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= num_cmds;
                        wcnt_q   <= '0;
                        if (num_cmds == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                            hold_q  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        // abort wins over an accept, so a final word arriving now never produces a strobe
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b0;
                        wcnt_q  <= '0;
                    end else if (bus.word_valid) begin
                        pack_q <= pack_d;
                        if (wcnt_q == WCW'(WPC - 1)) begin
                            wcnt_q     <= '0;
                            state_q    <= WRITE;
                            we_q       <= 1'b1;
                            cmd_addr_q <= addr_q;
                            cmd_data_q <= pack_d;
                        end else begin
                            wcnt_q <= wcnt_q + WCW'(1);
                        end
                    end
                end
                WRITE: begin
                    we_q <= 1'b0;
                    if (abort) begin
                        // the registered strobe is already on the bus; abort just stops the sequence
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b0;
                    end else begin
                        addr_q   <= addr_q + CMD_ADDR_WIDTH'(1);
                        remain_q <= remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: random word streams against a queue-based model of
// the expected command writes (address = base + i mod 256, data = 4 words concatenated).
module tb_prog_loader;
    localparam int CW  = 128;
    localparam int AW  = 8;
    localparam int WW  = 32;
    localparam int WPC = CW / WW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_cmds = '0;
    logic          proc_hold;
    logic          busy;
    logic          done;

    prog_loader_if #(.CMD_WIDTH(CW), .CMD_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus();

    prog_loader #(.CMD_WIDTH(CW), .CMD_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .num_cmds(num_cmds),
        .bus(bus),
        .proc_hold(proc_hold),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Monitor state (only written by the monitor processes below)
    int          cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_cnt = 0;
    logic        busy_at_done = 1'b0;
    logic [AW-1:0] wq_addr[$];
    logic [CW-1:0] wq_data[$];
    int          wq_cyc[$];
    int          wq_acc[$];

    logic [WW-1:0] words[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.word_valid && bus.word_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge clk) begin
        if (bus.write_prog_enable) begin
            wq_addr.push_back(bus.cmd_addr);
            wq_data.push_back(bus.cmd_data);
            wq_cyc.push_back(cyc);
            wq_acc.push_back(acc_cnt);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            busy_at_done = busy | proc_hold;
        end
        if (busy) busy_cnt = busy_cnt + 1;
    end

    // Reference: command i is words 4i..4i+3 with the first word in the MSBs
    function automatic logic [CW-1:0] pack_ref(input int first);
        logic [CW-1:0] d;
        d = '0;
        for (int j = 0; j < WPC; j++) d = (d << WW) | CW'(words[first + j]);
        return d;
    endfunction

    task automatic gen_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] n, output int s);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        num_cmds = n;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        base_addr = AW'($urandom);
        num_cmds = (AW+1)'($urandom);
    endtask

    task automatic feed(input int first, input int cnt, input int maxgap);
        for (int i = 0; i < cnt; i++) begin
            int gap;
            int g;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) begin
                bus.word_valid = 1'b0;
                bus.word_in = $urandom;
                @(negedge clk);
            end
            bus.word_valid = 1'b1;
            bus.word_in = words[first + i];
            g = 0;
            while (!bus.word_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) begin
                checks++;
                failures++;
                $display("FAIL feed_timeout word=%0d ready=%0b required=1", first + i, bus.word_ready);
            end
            @(negedge clk);
        end
        bus.word_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (done_cnt < target && g < 300) begin
            @(posedge clk);
            g++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL done_timeout done_count=%0d required=%0d", done_cnt, target);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.write_prog_enable, bus.cmd_addr, bus.cmd_data, proc_hold, busy, done, bus.word_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs we=%0b addr=%h data=%h hold=%0b busy=%0b done=%0b ready=%0b required all 0",
                     bus.write_prog_enable, bus.cmd_addr, bus.cmd_data, proc_hold, busy, done, bus.word_ready);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.write_prog_enable, proc_hold, busy, done, bus.word_ready} !== 5'b0) begin
            failures++;
            $display("FAIL idle_after_reset we=%0b hold=%0b busy=%0b done=%0b ready=%0b required all 0",
                     bus.write_prog_enable, proc_hold, busy, done, bus.word_ready);
        end
    endtask

    task automatic test_basic();
        int s, wb, db, bb;
        words.delete();
        words.push_back(32'h01000000);
        for (int i = 2; i <= 8; i++) words.push_back(32'(i));
        wb = wq_addr.size(); db = done_cnt; bb = busy_cnt;
        pulse_start(8'h10, 9'd2, s);
        feed(0, 8, 0);
        wait_done(db + 1);
        checks++;
        if (wq_addr.size() - wb !== 2) begin
            failures++;
            $display("FAIL basic_write_count got=%0d required=2", wq_addr.size() - wb);
        end else begin
            checks += 6;
            if (wq_addr[wb] !== 8'h10) begin failures++; $display("FAIL basic_addr0 got=%h required=10", wq_addr[wb]); end
            if (wq_data[wb] !== 128'h01000000_00000002_00000003_00000004) begin
                failures++; $display("FAIL basic_data0 got=%h required=01000000000000020000000300000004", wq_data[wb]);
            end
            if (wq_addr[wb+1] !== 8'h11) begin failures++; $display("FAIL basic_addr1 got=%h required=11", wq_addr[wb+1]); end
            if (wq_data[wb+1] !== 128'h00000005_00000006_00000007_00000008) begin
                failures++; $display("FAIL basic_data1 got=%h required=00000005000000060000000700000008", wq_data[wb+1]);
            end
            if (wq_cyc[wb+1] - wq_cyc[wb] !== 5) begin
                failures++; $display("FAIL basic_spacing got=%0d required=5", wq_cyc[wb+1] - wq_cyc[wb]);
            end
            if (wq_cyc[wb] - s !== 5) begin
                failures++; $display("FAIL basic_first_write_latency got=%0d required=5", wq_cyc[wb] - s);
            end
        end
        checks += 3;
        if (done_cyc - s !== 11) begin failures++; $display("FAIL basic_done_latency got=%0d required=11", done_cyc - s); end
        if (busy_at_done !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%0b required=0", busy_at_done); end
        if (busy_cnt - bb !== 10) begin failures++; $display("FAIL basic_busy_cycles got=%0d required=10", busy_cnt - bb); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - db !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d required=1", done_cnt - db); end
    endtask

    task automatic test_backpressure();
        int s, wb, db, ab;
        gen_words(8);
        wb = wq_addr.size(); db = done_cnt; ab = acc_cnt;
        pulse_start(8'h10, 9'd2, s);
        feed(0, 8, 2);
        wait_done(db + 1);
        checks++;
        if (wq_addr.size() - wb !== 2) begin
            failures++;
            $display("FAIL bp_write_count got=%0d required=2", wq_addr.size() - wb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks += 3;
                if (wq_addr[wb+i] !== AW'(8'h10 + i)) begin
                    failures++; $display("FAIL bp_addr%0d got=%h required=%h", i, wq_addr[wb+i], AW'(8'h10 + i));
                end
                if (wq_data[wb+i] !== pack_ref(4*i)) begin
                    failures++; $display("FAIL bp_data%0d got=%h required=%h", i, wq_data[wb+i], pack_ref(4*i));
                end
                if (wq_acc[wb+i] - ab !== 4*(i+1)) begin
                    failures++; $display("FAIL bp_words_before_write%0d got=%0d required=%0d", i, wq_acc[wb+i] - ab, 4*(i+1));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int s, wb, db;
        gen_words(8);
        wb = wq_addr.size(); db = done_cnt;
        pulse_start(8'hFF, 9'd2, s);
        feed(0, 8, 1);
        wait_done(db + 1);
        checks++;
        if (wq_addr.size() - wb !== 2) begin
            failures++;
            $display("FAIL wrap_write_count got=%0d required=2", wq_addr.size() - wb);
        end else begin
            checks += 4;
            if (wq_addr[wb] !== 8'hFF) begin failures++; $display("FAIL wrap_addr0 got=%h required=ff", wq_addr[wb]); end
            if (wq_addr[wb+1] !== 8'h00) begin failures++; $display("FAIL wrap_addr1 got=%h required=00", wq_addr[wb+1]); end
            if (wq_data[wb] !== pack_ref(0)) begin failures++; $display("FAIL wrap_data0 got=%h required=%h", wq_data[wb], pack_ref(0)); end
            if (wq_data[wb+1] !== pack_ref(4)) begin failures++; $display("FAIL wrap_data1 got=%h required=%h", wq_data[wb+1], pack_ref(4)); end
        end
    endtask

    task automatic test_zero();
        int s, wb, db, bb;
        wb = wq_addr.size(); db = done_cnt; bb = busy_cnt;
        pulse_start(AW'($urandom), 9'd0, s);
        wait_done(db + 1);
        repeat (3) @(negedge clk);
        checks += 4;
        if (wq_addr.size() - wb !== 0) begin failures++; $display("FAIL zero_write_count got=%0d required=0", wq_addr.size() - wb); end
        if (done_cyc - s !== 1) begin failures++; $display("FAIL zero_done_latency got=%0d required=1", done_cyc - s); end
        if (busy_cnt - bb !== 0) begin failures++; $display("FAIL zero_busy_cycles got=%0d required=0", busy_cnt - bb); end
        if (done_cnt - db !== 1) begin failures++; $display("FAIL zero_done_pulses got=%0d required=1", done_cnt - db); end
    endtask

    task automatic test_abort();
        int s, wb, db;
        logic [AW-1:0] b;
        logic [CW-1:0] exp0;
        b = AW'($urandom);
        gen_words(12);
        exp0 = pack_ref(0);
        wb = wq_addr.size(); db = done_cnt;
        pulse_start(b, 9'd3, s);
        feed(0, 6, 1);
        abort = 1'b1;
        bus.word_valid = 1'b1;
        bus.word_in = words[6];
        @(negedge clk);
        abort = 1'b0;
        bus.word_valid = 1'b0;
        checks++;
        if ({busy, proc_hold, bus.word_ready} !== 3'b000) begin
            failures++;
            $display("FAIL abort_drop busy=%0b hold=%0b ready=%0b required all 0", busy, proc_hold, bus.word_ready);
        end
        repeat (8) @(negedge clk);
        checks += 2;
        if (done_cnt - db !== 0) begin failures++; $display("FAIL abort_done_pulses got=%0d required=0", done_cnt - db); end
        if (wq_addr.size() - wb !== 1) begin
            failures++;
            $display("FAIL abort_write_count got=%0d required=1", wq_addr.size() - wb);
        end else begin
            checks += 2;
            if (wq_addr[wb] !== b) begin failures++; $display("FAIL abort_addr got=%h required=%h", wq_addr[wb], b); end
            if (wq_data[wb] !== exp0) begin failures++; $display("FAIL abort_data got=%h required=%h", wq_data[wb], exp0); end
        end
        // a fresh single-command load after the abort
        b = AW'($urandom);
        gen_words(4);
        wb = wq_addr.size(); db = done_cnt;
        pulse_start(b, 9'd1, s);
        feed(0, 4, 1);
        wait_done(db + 1);
        checks++;
        if (wq_addr.size() - wb !== 1) begin
            failures++;
            $display("FAIL post_abort_write_count got=%0d required=1", wq_addr.size() - wb);
        end else begin
            checks += 2;
            if (wq_addr[wb] !== b) begin failures++; $display("FAIL post_abort_addr got=%h required=%h", wq_addr[wb], b); end
            if (wq_data[wb] !== pack_ref(0)) begin failures++; $display("FAIL post_abort_data got=%h required=%h", wq_data[wb], pack_ref(0)); end
        end
    endtask

    task automatic test_reset_midload();
        int s, wb, db;
        logic [AW-1:0] b;
        b = AW'($urandom);
        gen_words(8);
        db = done_cnt;
        pulse_start(b, 9'd2, s);
        feed(0, 5, 0);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.write_prog_enable, bus.cmd_addr, bus.cmd_data, proc_hold, busy, done, bus.word_ready} !== '0) begin
            failures++;
            $display("FAIL midload_reset we=%0b addr=%h data=%h hold=%0b busy=%0b done=%0b ready=%0b required all 0",
                     bus.write_prog_enable, bus.cmd_addr, bus.cmd_data, proc_hold, busy, done, bus.word_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        wb = wq_addr.size();
        repeat (6) @(negedge clk);
        checks += 3;
        if (wq_addr.size() - wb !== 0) begin failures++; $display("FAIL midload_writes_after got=%0d required=0", wq_addr.size() - wb); end
        if (done_cnt - db !== 0) begin failures++; $display("FAIL midload_done_pulses got=%0d required=0", done_cnt - db); end
        if ({busy, bus.word_ready} !== 2'b00) begin failures++; $display("FAIL midload_idle busy=%0b ready=%0b required 0", busy, bus.word_ready); end
    endtask

    task automatic test_start_while_busy();
        int s, wb, db;
        logic [AW-1:0] b;
        b = AW'($urandom);
        gen_words(8);
        wb = wq_addr.size(); db = done_cnt;
        pulse_start(b, 9'd2, s);
        feed(0, 2, 0);
        start = 1'b1;
        base_addr = b + 8'h40;
        num_cmds = 9'd5;
        @(negedge clk);
        start = 1'b0;
        feed(2, 6, 0);
        wait_done(db + 1);
        repeat (4) @(negedge clk);
        checks += 2;
        if (bus.word_ready !== 1'b0) begin failures++; $display("FAIL swb_ready_after got=%0b required=0", bus.word_ready); end
        if (wq_addr.size() - wb !== 2) begin
            failures++;
            $display("FAIL swb_write_count got=%0d required=2", wq_addr.size() - wb);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks += 2;
                if (wq_addr[wb+i] !== AW'(b + i)) begin failures++; $display("FAIL swb_addr%0d got=%h required=%h", i, wq_addr[wb+i], AW'(b + i)); end
                if (wq_data[wb+i] !== pack_ref(4*i)) begin failures++; $display("FAIL swb_data%0d got=%h required=%h", i, wq_data[wb+i], pack_ref(4*i)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            int s, wb, db, n;
            logic [AW-1:0] b;
            b = AW'($urandom);
            n = $urandom_range(4, 1);
            gen_words(4*n);
            wb = wq_addr.size(); db = done_cnt;
            pulse_start(b, (AW+1)'(n), s);
            feed(0, 4*n, (k % 2 == 0) ? 0 : 3);
            wait_done(db + 1);
            checks += 2;
            if (busy_at_done !== 1'b0) begin failures++; $display("FAIL b2b%0d_busy_at_done got=%0b required=0", k, busy_at_done); end
            if (wq_addr.size() - wb !== n) begin
                failures++;
                $display("FAIL b2b%0d_write_count got=%0d required=%0d", k, wq_addr.size() - wb, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks += 2;
                    if (wq_addr[wb+i] !== AW'(int'(b) + i)) begin
                        failures++; $display("FAIL b2b%0d_addr%0d got=%h required=%h", k, i, wq_addr[wb+i], AW'(int'(b) + i));
                    end
                    if (wq_data[wb+i] !== pack_ref(4*i)) begin
                        failures++; $display("FAIL b2b%0d_data%0d got=%h required=%h", k, i, wq_data[wb+i], pack_ref(4*i));
                    end
                end
            end
        end
    endtask

    initial begin
        bus.word_in = '0;
        bus.word_valid = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_abort();
        test_reset_midload();
        test_start_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
